// File: rtl/ex_stage_pipe.sv
// ID->EX stage register with a 2-entry skid buffer: 1-cycle latency, 1 transfer/cycle, o_ready registered (!skid valid).
// Optional NOVA_STAGE_PERF_EN adds o_stall_cnt, a saturating count of cycles held by downstream back-pressure.
module ex_stage_pipe #(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       CTRL_W       = 16,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [CTRL_W-1:0] CTRL_RESET   = {CTRL_W{1'b0}}
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [CTRL_W-1:0]      i_ctrl,
  input  logic signed [XLEN-1:0] i_rs1,
  input  logic signed [XLEN-1:0] i_rs2,
  input  logic signed [XLEN-1:0] i_imm,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [XLEN-1:0]        o_pc,
  output logic [CTRL_W-1:0]      o_ctrl,
  output logic signed [XLEN-1:0] o_rs1,
  output logic signed [XLEN-1:0] o_rs2,
  output logic signed [XLEN-1:0] o_imm
`ifdef NOVA_STAGE_PERF_EN
  ,
  output logic [31:0]            o_stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
  } pay_t;

  localparam pay_t PAY_RESET = '{pc: RESET_VECTOR, ctrl: CTRL_RESET,
                                 rs1: '0, rs2: '0, imm: '0};

  pay_t m_q;
  pay_t s_q;
  pay_t in_pay;
  logic m_vld_q;
  logic s_vld_q;
  logic accept;
  logic take;

  assign in_pay = '{pc: i_pc, ctrl: i_ctrl, rs1: i_rs1, rs2: i_rs2, imm: i_imm};

  assign o_ready = !s_vld_q;
  assign o_valid = m_vld_q;
  assign accept  = i_valid & o_ready;
  assign take    = m_vld_q & i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= PAY_RESET;
      s_q     <= PAY_RESET;
    end else if (!m_vld_q) begin
      if (accept) begin
        m_q     <= in_pay;
        m_vld_q <= 1'b1;
      end
    end else if (!s_vld_q) begin
      // BUSY: a take frees M for the new payload; otherwise it parks in S
      if (accept && take) begin
        m_q <= in_pay;
      end else if (accept) begin
        s_q     <= in_pay;
        s_vld_q <= 1'b1;
      end else if (take) begin
        m_vld_q <= 1'b0;
      end
    end else if (take) begin
      m_q     <= s_q;
      s_vld_q <= 1'b0;
    end
  end

  assign o_pc   = m_q.pc;
  assign o_ctrl = m_q.ctrl;
  assign o_rs1  = m_q.rs1;
  assign o_rs2  = m_q.rs2;
  assign o_imm  = m_q.imm;

`ifdef NOVA_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;

  // flush deliberately leaves the counter alone
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stall_cnt_q <= '0;
    end else if (m_vld_q && !i_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe; build with NOVA_STAGE_PERF_EN to cover the stall counter.
module tb_ex_stage_pipe;

  localparam logic [31:0] RV = 32'hDEAD_0000;
  localparam logic [15:0] CR = 16'h00F0;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } pay_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_vld = 1'b0;
  logic               out_rdy_dut;
  logic [31:0]        in_pc = '0;
  logic [15:0]        in_ctrl;
  logic signed [31:0] in_rs1, in_rs2, in_imm;
  logic               out_vld;
  logic               ds_rdy = 1'b1;
  logic [31:0]        out_pc;
  logic [15:0]        out_ctrl;
  logic signed [31:0] out_rs1, out_rs2, out_imm;
`ifdef NOVA_STAGE_PERF_EN
  logic [31:0]        stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_takes  = 0;
  pay_t exp_q[$];
  pay_t in_p;

  always #5 clk = ~clk;

  // Hand-chosen payload derivation so every field differs per pc
  function automatic pay_t mk(input logic [31:0] pc);
    pay_t p;
    p.pc   = pc;
    p.ctrl = pc[15:0] ^ 16'h5A3C;
    p.rs1  = pc * 3 + 1;
    p.rs2  = ~pc;
    p.imm  = 32'd0 - (pc >> 2);
    return p;
  endfunction

  always_comb begin
    in_p    = mk(in_pc);
    in_ctrl = in_p.ctrl;
    in_rs1  = in_p.rs1;
    in_rs2  = in_p.rs2;
    in_imm  = in_p.imm;
  end

  ex_stage_pipe #(
    .XLEN(32), .CTRL_W(16), .RESET_VECTOR(RV), .CTRL_RESET(CR)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(in_vld), .o_ready(out_rdy_dut),
    .i_pc(in_pc), .i_ctrl(in_ctrl), .i_rs1(in_rs1), .i_rs2(in_rs2), .i_imm(in_imm),
    .o_valid(out_vld), .i_ready(ds_rdy), .o_pc(out_pc), .o_ctrl(out_ctrl),
    .o_rs1(out_rs1), .o_rs2(out_rs2), .o_imm(out_imm)
`ifdef NOVA_STAGE_PERF_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_vld"},  out_vld, 1'b0);
    chk({tag, "_rdy"},  out_rdy_dut, 1'b1);
    chk({tag, "_pc"},   out_pc, RV);
    chk({tag, "_ctrl"}, out_ctrl, CR);
    chk({tag, "_ops"},  {out_rs1, out_rs2, out_imm}, 96'd0);
  endtask

  // Monitor: score the output transfer first, then apply kills, then record accepted input
  always @(negedge clk) begin
    if (out_vld && ds_rdy && rst_n) begin
      pay_t got;
      n_takes++;
      got = '{pc: out_pc, ctrl: out_ctrl, rs1: out_rs1, rs2: out_rs2, imm: out_imm};
      if (exp_q.size() == 0) begin
        chk("unexpected_out", got, '0);
      end else begin
        chk("out_payload", got, exp_q.pop_front());
      end
    end
    if (!rst_n || flush) exp_q.delete();
    else if (in_vld && out_rdy_dut) exp_q.push_back(mk(in_pc));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_takes;
    // reset while upstream offers 0x100
    in_vld = 1'b1; in_pc = 32'h100; ds_rdy = 1'b1;
    tick(); tick();
    chk_reset_state("reset");
    tick(); rst_n = 1'b1;
    tick(); in_vld = 1'b0;
    @(negedge clk);
    chk("lat1_vld", out_vld, 1'b1);
    chk("lat1_pc", out_pc, 32'h100);
    tick(); tick();

    // streaming 16 pcs at full rate
    for (int k = 0; k < 16; k++) begin
      tick(); in_vld = 1'b1; in_pc = 32'(k * 4);
      @(negedge clk);
      chk("stream_rdy", out_rdy_dut, 1'b1);
      if (k > 0) chk("stream_vld", out_vld, 1'b1);
    end
    tick(); in_vld = 1'b0;
    @(negedge clk);
    chk("stream_last_vld", out_vld, 1'b1);
    tick();
    @(negedge clk);
    chk("stream_drained", out_vld, 1'b0);

    // back-pressure into FULL, then release
    tick(); ds_rdy = 1'b0; in_vld = 1'b1; in_pc = 32'h10;
    tick(); in_pc = 32'h14;
    tick(); in_vld = 1'b0;
    @(negedge clk);
    chk("full_rdy", out_rdy_dut, 1'b0);
    chk("full_pc", out_pc, 32'h10);
    tick(); tick();
    @(negedge clk);
    chk("full_stable", {out_pc, out_ctrl, out_rs1}, {mk(32'h10).pc, mk(32'h10).ctrl, mk(32'h10).rs1});
    tick(); ds_rdy = 1'b1;
    tick();
    @(negedge clk);
    chk("after_take_rdy", out_rdy_dut, 1'b1);
    chk("after_take_pc", out_pc, 32'h14);
    tick(); tick();

    // flush in FULL with 0x18 offered
    tick(); ds_rdy = 1'b0; in_vld = 1'b1; in_pc = 32'h20;
    tick(); in_pc = 32'h24;
    tick(); in_pc = 32'h18; flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_rdy", out_rdy_dut, 1'b0);
    tick(); flush = 1'b0; in_vld = 1'b0;
    chk_reset_state("flush");
    ds_rdy = 1'b1;
    repeat (4) tick();

    // reset in FULL while downstream is ready
    ds_rdy = 1'b0; in_vld = 1'b1; in_pc = 32'h30;
    tick(); in_pc = 32'h34;
    tick(); in_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_rdy", out_rdy_dut, 1'b0);
    tick(); rst_n = 1'b0; ds_rdy = 1'b1;
    tick(); rst_n = 1'b1;
    chk_reset_state("midrst");
    repeat (3) tick();
    exp_takes = 19;

`ifdef NOVA_STAGE_PERF_EN
    // 5 stall cycles, flush (with a take), then 3 more stalls
    in_vld = 1'b1; in_pc = 32'h40; ds_rdy = 1'b0;
    tick(); in_vld = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("stall_cnt5", stall_cnt, 32'd5);
    flush = 1'b1; ds_rdy = 1'b1;
    tick(); flush = 1'b0; in_vld = 1'b1; in_pc = 32'h44; ds_rdy = 1'b0;
    tick(); in_vld = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("stall_cnt8", stall_cnt, 32'd8);
    ds_rdy = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    exp_takes = 21;
`endif

    @(negedge clk);
    chk("take_count", n_takes, exp_takes);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised ID→EX pipeline stage register for the NOVA core; next generation of the plain execute-stage register.
- Carries pc, control bundle, rs1, rs2 and imm with a valid/ready handshake on both sides.
- A 2-entry skid buffer keeps o_ready registered, so there is no combinational ready path through the stage.
- Supports pipeline flush (branch/exception kill) and sustains full throughput of 1 transfer per cycle.

Parameters:
- XLEN, 32, width of pc/rs1/rs2/imm.
- CTRL_W, 16, width of the packed control bundle.
- RESET_VECTOR, 32'h0000_0000, value of o_pc after reset/flush.
- CTRL_RESET, {CTRL_W{1'b0}}, default (NOP) control value after reset/flush.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_flush  in  1  kill all held entries; drop this cycle's input.
- i_valid  in  1  upstream has a payload.
- o_ready  out  1  stage can accept; registered.
- i_pc  in  XLEN  instruction pc.
- i_ctrl  in  CTRL_W  control bundle.
- i_rs1, i_rs2, i_imm  in  XLEN each  operands (signed).
- o_valid  out  1  payload on outputs is valid.
- i_ready  in  1  downstream accepts.
- o_pc  out  XLEN  held pc.
- o_ctrl  out  CTRL_W  held control.
- o_rs1, o_rs2, o_imm  out  XLEN each  held operands (signed).

Behaviour:
- Storage: main entry M drives all outputs; skid entry S sits behind it. Each has a valid bit. o_valid = M.valid; o_ready = !S.valid.
- Definitions: accept = i_valid & o_ready; take = o_valid & i_ready.
- Reset (i_reset_n=0 at an edge): M.valid=S.valid=0, o_ready=1, o_pc=RESET_VECTOR, o_ctrl=CTRL_RESET, o_rs1/o_rs2/o_imm=0. Reset overrides flush and all traffic, including mid-transfer.
- Flush (i_flush=1, out of reset): next cycle is identical to the reset state. The concurrent input is dropped. A concurrent take still counts downstream.
- States: EMPTY (M invalid), BUSY (M valid, S invalid), FULL (both valid).
- EMPTY, on accept: M←in → BUSY.
- BUSY, accept & take: M←in, stay in BUSY.
- BUSY, accept & !take: S←in → FULL.
- BUSY, take & !accept: → EMPTY; M payload holds.
- BUSY, neither: hold.
- FULL (o_ready=0, no accept), on take: M←S, S.valid←0 → BUSY.
- FULL, !take: hold all.
- Latency: accept to o_valid is 1 cycle. Throughput: 1 per cycle while i_ready=1.
- Ordering: strict FIFO; no payload is lost or duplicated.
- Stability: while o_valid & !i_ready, all outputs stay bit-stable.
- Payload outputs are defined only when o_valid=1, except after reset/flush, where the defaults above are required.
- i_valid is ignored while o_ready=0. Upstream holds its payload until accepted.
- No combinational path from i_ready to o_ready, or from any input to any output.

Optional Feature:
- Macro: NOVA_STAGE_PERF_EN.
- Defined: adds output o_stall_cnt [31:0]. It increments every cycle o_valid & !i_ready, saturates at 32'hFFFF_FFFF, and clears on reset only (not on flush).
- Not defined: port and counter are absent; no other change.

Test Plan:
- Reset with i_valid=1, i_pc=0x100 → o_valid=0, o_ready=1, o_pc=RESET_VECTOR, o_ctrl=CTRL_RESET; release reset, next edge accepts 0x100, o_valid=1 one cycle later.
- Streaming pcs 0x0,0x4,…,0x3C, i_ready=1 throughout → 16 outputs in order on 16 consecutive cycles, o_ready always 1.
- Hold i_ready=0 after 0x10 is accepted, then send 0x14 → FULL, o_ready=0, o_pc stays 0x10. Raise i_ready → 0x10 then 0x14 delivered; o_ready returns to 1 after the first take.
- i_flush in FULL state with i_valid=1 (pc 0x18) → next cycle o_valid=0, o_ready=1, defaults on outputs; 0x18 never appears.
- Reset asserted in FULL state with i_ready=1 → reset state next cycle; no output transfer after reset.
- With NOVA_STAGE_PERF_EN: 5 back-pressure cycles, then flush, then 3 more → o_stall_cnt=8; after reset → 0.
